// File: rtl/id_ex_stage_if.sv
`default_nettype none
// ============================================================================
//  Module   : id_ex_stage_if
//  Purpose  : Bundles the decode-side handshake/payload and the EX-side
//             handshake/payload of the ID->EX pipeline register.
//  Modports : master - decode + EX consumer side (drives id_*, ex_ready,
//                      flush; observes id_ready and ex_*)
//             slave  - the id_ex_stage register itself
//  Revision : 1.0  initial release
// ============================================================================
interface id_ex_stage_if #(
    parameter int XLEN = 64
);
    // decode side
    logic            id_valid;
    logic            id_ready;
    logic [XLEN-1:0] id_pc;
    logic [XLEN-1:0] id_imm;
    logic [XLEN-1:0] id_gpr_data1;
    logic [XLEN-1:0] id_gpr_data2;
    logic [4:0]      id_rs1;
    logic [4:0]      id_rs2;
    logic            id_rs1_used;
    logic            id_rs2_used;
    logic [4:0]      id_rd;
    logic            id_rd_wen;
    logic            id_is_load;
    logic [11:0]     id_ctrl;
    logic [2:0]      id_branch_op;

    // EX side
    logic            ex_ready;
    logic            flush;
    logic            ex_valid;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] ex_imm;
    logic [XLEN-1:0] ex_gpr_data1;
    logic [XLEN-1:0] ex_gpr_data2;
    logic            ex_fw_en1;
    logic            ex_fw_en2;
    logic [11:0]     ex_ctrl;
    logic [2:0]      ex_branch_op;
    logic [4:0]      ex_rd;
    logic            ex_rd_wen;
    logic            ex_is_load;

    modport master (
        output id_valid, id_pc, id_imm, id_gpr_data1, id_gpr_data2,
               id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_rd, id_rd_wen, id_is_load, id_ctrl, id_branch_op,
               ex_ready, flush,
        input  id_ready,
               ex_valid, ex_pc, ex_imm, ex_gpr_data1, ex_gpr_data2,
               ex_fw_en1, ex_fw_en2, ex_ctrl, ex_branch_op,
               ex_rd, ex_rd_wen, ex_is_load
    );

    modport slave (
        input  id_valid, id_pc, id_imm, id_gpr_data1, id_gpr_data2,
               id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_rd, id_rd_wen, id_is_load, id_ctrl, id_branch_op,
               ex_ready, flush,
        output id_ready,
               ex_valid, ex_pc, ex_imm, ex_gpr_data1, ex_gpr_data2,
               ex_fw_en1, ex_fw_en2, ex_ctrl, ex_branch_op,
               ex_rd, ex_rd_wen, ex_is_load
    );
endinterface
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module   : id_ex_stage
//  Purpose  : ID->EX pipeline register for the EX-stage ALU. Captures the
//             decoded instruction, generates the MEM->EX forwarding enables,
//             detects load-use hazards and inserts bubbles, and honours
//             valid/ready backpressure and branch flush.
//  Ports    : clk   - clock, rising edge
//             rst_n - asynchronous active-low reset
//             bus   - id_ex_stage_if.slave (decode handshake + payload in,
//                     EX handshake + payload out)
//  Params   : XLEN     - datapath width
//             LU_STALL - bubbles owed to a load-use hazard on a load in EX
//                        (one fewer when the load has reached MEM)
//  Revision : 1.0  initial release
// ============================================================================
module id_ex_stage #(
    parameter int XLEN     = 64,
    parameter int LU_STALL = 2
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    id_ex_stage_if.slave  bus
);

    // ------------------------------------------------------------------
    // Stall counter encoding. The counter holds the number of bubbles
    // still owed AFTER the current cycle; the hazard cycle itself is the
    // first bubble, so the values loaded are one less than the total.
    // ------------------------------------------------------------------
    localparam int CNT_W = (LU_STALL > 1) ? $clog2(LU_STALL) : 1;
    localparam int c_LEFT_EX  = (LU_STALL > 0) ? LU_STALL - 1 : 0;
    localparam int c_LEFT_MEM = (LU_STALL > 1) ? LU_STALL - 2 : 0;

    localparam logic [CNT_W-1:0] c_ST_RUN      = CNT_W'(0);
    localparam logic [CNT_W-1:0] c_ST_WAIT_EX  = CNT_W'(c_LEFT_EX);
    localparam logic [CNT_W-1:0] c_ST_WAIT_MEM = CNT_W'(c_LEFT_MEM);
    localparam logic [CNT_W-1:0] c_ONE         = CNT_W'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic            r_ex_valid;
    logic [XLEN-1:0] r_ex_pc;
    logic [XLEN-1:0] r_ex_imm;
    logic [XLEN-1:0] r_ex_gpr_data1;
    logic [XLEN-1:0] r_ex_gpr_data2;
    logic            r_ex_fw_en1;
    logic            r_ex_fw_en2;
    logic [11:0]     r_ex_ctrl;
    logic [2:0]      r_ex_branch_op;
    logic [4:0]      r_ex_rd;
    logic            r_ex_rd_wen;
    logic            r_ex_is_load;

    // Shadow of the instruction now in MEM (only what hazard checks need)
    logic [4:0]      r_mem_rd;
    logic            r_mem_wen;
    logic            r_mem_load;

    logic [CNT_W-1:0] r_stall_cnt;

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic w_adv;
    logic w_in;
    logic w_out;
    logic w_id_ready;
    logic w_stall_idle;
    logic w_ex_alu_src;
    logic w_ex_load_src;
    logic w_mem_load_src;
    logic w_hz_ex;
    logic w_hz_mem;
    logic w_hazard;
    logic w_fw1;
    logic w_fw2;

    // A source matches a producer only when the source is really read, the
    // producer really writes, indices agree and the register is not x0.
    function automatic logic f_match(
        input logic       used,
        input logic [4:0] rs,
        input logic [4:0] rd,
        input logic       wen
    );
        return used & wen & (rs == rd) & (rs != 5'd0);
    endfunction

    assign w_adv  = ~r_ex_valid | bus.ex_ready;
    assign w_out  = r_ex_valid & bus.ex_ready;

    assign w_ex_alu_src   = r_ex_valid & r_ex_rd_wen & ~r_ex_is_load;
    assign w_ex_load_src  = r_ex_valid & r_ex_rd_wen &  r_ex_is_load;
    assign w_mem_load_src = r_mem_wen & r_mem_load;

    // Hazards are only meaningful for an instruction actually presented.
    assign w_hz_ex  = bus.id_valid &
                      (f_match(bus.id_rs1_used, bus.id_rs1, r_ex_rd, w_ex_load_src) |
                       f_match(bus.id_rs2_used, bus.id_rs2, r_ex_rd, w_ex_load_src));
    assign w_hz_mem = bus.id_valid &
                      (f_match(bus.id_rs1_used, bus.id_rs1, r_mem_rd, w_mem_load_src) |
                       f_match(bus.id_rs2_used, bus.id_rs2, r_mem_rd, w_mem_load_src));
    assign w_hazard = w_hz_ex | w_hz_mem;

    assign w_stall_idle = (r_stall_cnt == c_ST_RUN);
    assign w_id_ready   = w_adv & ~w_hazard & w_stall_idle & ~bus.flush;
    assign w_in         = bus.id_valid & w_id_ready;

    // The instruction captured this edge sits directly behind the one
    // leaving EX, which will be in MEM when the new one executes. Loads
    // cannot be bypassed here; those are covered by the stall path.
    assign w_fw1 = f_match(bus.id_rs1_used, bus.id_rs1, r_ex_rd, w_ex_alu_src);
    assign w_fw2 = f_match(bus.id_rs2_used, bus.id_rs2, r_ex_rd, w_ex_alu_src);

    // ------------------------------------------------------------------
    // Valid bit
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_valid <= 1'b0;
        end else if (bus.flush) begin
            r_ex_valid <= 1'b0;
        end else if (w_in) begin
            r_ex_valid <= 1'b1;
        end else if (w_out) begin
            r_ex_valid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Payload: loads only on an accepted instruction, otherwise holds
    // (bubbles leave stale payload behind a cleared valid).
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_pc        <= '0;
            r_ex_imm       <= '0;
            r_ex_gpr_data1 <= '0;
            r_ex_gpr_data2 <= '0;
            r_ex_fw_en1    <= 1'b0;
            r_ex_fw_en2    <= 1'b0;
            r_ex_ctrl      <= '0;
            r_ex_branch_op <= '0;
            r_ex_rd        <= '0;
            r_ex_rd_wen    <= 1'b0;
            r_ex_is_load   <= 1'b0;
        end else if (w_in) begin
            r_ex_pc        <= bus.id_pc;
            r_ex_imm       <= bus.id_imm;
            r_ex_gpr_data1 <= bus.id_gpr_data1;
            r_ex_gpr_data2 <= bus.id_gpr_data2;
            r_ex_fw_en1    <= w_fw1;
            r_ex_fw_en2    <= w_fw2;
            r_ex_ctrl      <= bus.id_ctrl;
            r_ex_branch_op <= bus.id_branch_op;
            r_ex_rd        <= bus.id_rd;
            r_ex_rd_wen    <= bus.id_rd_wen;
            r_ex_is_load   <= bus.id_is_load;
        end
    end

    // ------------------------------------------------------------------
    // MEM shadow: follows EX on every advance. A bubble, or an instruction
    // killed by flush, arrives in MEM with its write enable cleared.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_rd   <= '0;
            r_mem_wen  <= 1'b0;
            r_mem_load <= 1'b0;
        end else if (w_adv) begin
            r_mem_rd   <= r_ex_rd;
            r_mem_wen  <= r_ex_rd_wen & r_ex_valid & ~bus.flush;
            r_mem_load <= r_ex_is_load;
        end
    end

    // ------------------------------------------------------------------
    // Load-use stall counter: RUN(0) -> WAIT(n) on hazard, counts down on
    // each advance, frozen under backpressure, forced to RUN on flush.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= c_ST_RUN;
        end else if (bus.flush) begin
            r_stall_cnt <= c_ST_RUN;
        end else if (w_stall_idle) begin
            if (w_adv && w_hazard) begin
                r_stall_cnt <= w_hz_ex ? c_ST_WAIT_EX : c_ST_WAIT_MEM;
            end
        end else if (w_adv) begin
            r_stall_cnt <= r_stall_cnt - c_ONE;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.id_ready     = w_id_ready;
    assign bus.ex_valid     = r_ex_valid;
    assign bus.ex_pc        = r_ex_pc;
    assign bus.ex_imm       = r_ex_imm;
    assign bus.ex_gpr_data1 = r_ex_gpr_data1;
    assign bus.ex_gpr_data2 = r_ex_gpr_data2;
    assign bus.ex_fw_en1    = r_ex_fw_en1;
    assign bus.ex_fw_en2    = r_ex_fw_en2;
    assign bus.ex_ctrl      = r_ex_ctrl;
    assign bus.ex_branch_op = r_ex_branch_op;
    assign bus.ex_rd        = r_ex_rd;
    assign bus.ex_rd_wen    = r_ex_rd_wen;
    assign bus.ex_is_load   = r_ex_is_load;

endmodule
`default_nettype wire
